// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and frame geometry, common to the TX scheduler and the receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: uart_state_t (IDLE/START/DATA/STOP), UART_DATA_BITS, UART_OVERSAMPLE.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active requester at or after the pointer, wrapping modulo NUM_REQ.
// Latency: winner is combinational from req/pointer; pointer moves on the edge where advance is high.
// Backpressure: none; the caller only advances when it actually accepts the winner.
// Ports: BaudRate_clk, reset (async active-low), req[NUM_REQ], advance, winner[NUM_REQ] one-hot, any_req.
module uart_tx_scheduler_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               BaudRate_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_req
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] idx;

  // Scan from the pointer; the first hit wins, later hits are masked by any_req.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req      = 1'b1;
        winner[idx]  = 1'b1;
        win_idx      = idx;
      end
    end
  end

  // The requester just served drops to lowest priority.
  always_ff @(posedge BaudRate_clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (advance && any_req) begin
      ptr_q <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART TX line between NUM_REQ byte producers using round-robin arbitration.
// Latency: req seen in IDLE -> ack/grant/busy and start bit on the next edge; frame is (9+STOP_BITS)*OVERSAMPLE cycles.
// Backpressure: req is a level held until ack; requests are only sampled in IDLE, so they wait out a frame in progress.
// Ports: BaudRate_clk (OVERSAMPLE x baud), reset (async active-low), req[NUM_REQ], tx_data[8*NUM_REQ],
//        ack[NUM_REQ] (1-cycle pulse), grant[NUM_REQ] (one-hot owner), busy, UART_TX (idle high, LSB first),
//        TX_STATUS (1-cycle pulse after the last stop tick).
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 BaudRate_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] tx_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 UART_TX,
  output logic                 TX_STATUS
);

  localparam int STOP_TICKS = OVERSAMPLE * STOP_BITS;
  localparam int TICK_W     = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_t               state;
  logic [TICK_W-1:0]         tick;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] win_byte;
  logic [NUM_REQ-1:0]        winner;
  logic                      any_req;
  logic                      advance;

  // The pointer only moves when a frame is actually started.
  assign advance = (state == IDLE);

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .BaudRate_clk (BaudRate_clk),
    .reset        (reset),
    .req          (req),
    .advance      (advance),
    .winner       (winner),
    .any_req      (any_req)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_byte = tx_data[8*i +: 8];
    end
  end

  always_ff @(posedge BaudRate_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      ack       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      UART_TX   <= 1'b1;
      TX_STATUS <= 1'b0;
    end else begin
      ack       <= '0;
      TX_STATUS <= 1'b0;
      case (state)
        IDLE: begin
          UART_TX <= 1'b1;
          if (any_req) begin
            grant     <= winner;
            ack       <= winner;
            busy      <= 1'b1;
            shift_reg <= win_byte;
            UART_TX   <= 1'b0;
            tick      <= '0;
            bit_cnt   <= '0;
            state     <= START;
          end
        end
        START: begin
          if (tick == BIT_LAST) begin
            tick    <= '0;
            bit_cnt <= '0;
            UART_TX <= shift_reg[0];
            state   <= DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == BIT_LAST) begin
            tick <= '0;
            if (bit_cnt == LAST_BIT) begin
              UART_TX <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              // Drive the next bit directly from the pre-shift value so the line stays registered.
              UART_TX   <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          if (tick == STOP_LAST) begin
            tick      <= '0;
            TX_STATUS <= 1'b1;
            grant     <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
